// File: rtl/column_write_arbiter_pkg.sv
// Shared definitions for the column write arbiter and the column memory wrappers:
// default bus widths, FSM state encodings and requester port identifiers.
package column_write_arbiter_pkg;

  localparam int DEF_N_COLS  = 64;
  localparam int DEF_COL_W   = 6;
  localparam int DEF_ROW_W   = 10;
  localparam int DEF_PIX_W   = 8;
  localparam int DEF_TIMEOUT = 255;

  // Arbiter FSM states, kept as fixed encodings so existing decoders still match.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_DRIVE   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  // Requester identity: A is the HPS point plotter, B is the grid-row scanner.
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

endpackage

// File: rtl/column_write_arbiter_if.sv
// Bundle of the two requester handshakes, the shared column write bus and the
// status flags. "slave" is the arbiter's view, "master" the surrounding logic's.
interface column_write_arbiter_if
  import column_write_arbiter_pkg::*;
#(
  parameter int N_COLS = DEF_N_COLS,
  parameter int COL_W  = DEF_COL_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int PIX_W  = DEF_PIX_W
) ();

  logic              req_a;
  logic [COL_W-1:0]  col_a;
  logic [ROW_W-1:0]  row_a;
  logic [PIX_W-1:0]  color_a;
  logic              done_a;

  logic              req_b;
  logic [COL_W-1:0]  col_b;
  logic [ROW_W-1:0]  row_b;
  logic [PIX_W-1:0]  color_b;
  logic              done_b;

  logic [N_COLS-1:0] col_select;
  logic [ROW_W-1:0]  row_select;
  logic [PIX_W-1:0]  pixel_color;
  logic [N_COLS-1:0] return_sig;

  logic              busy;
  logic              timeout_err;
  logic              bad_col_err;

  modport slave (
    input  req_a, col_a, row_a, color_a,
    input  req_b, col_b, row_b, color_b,
    input  return_sig,
    output done_a, done_b,
    output col_select, row_select, pixel_color,
    output busy, timeout_err, bad_col_err
  );

  modport master (
    output req_a, col_a, row_a, color_a,
    output req_b, col_b, row_b, color_b,
    output return_sig,
    input  done_a, done_b,
    input  col_select, row_select, pixel_color,
    input  busy, timeout_err, bad_col_err
  );

endinterface

// File: rtl/column_write_arbiter_rr.sv
// Two-way round-robin grant. The last-served register moves only on a done
// pulse, so the port that just finished loses the next tie.
module rr_arbiter_2
  import column_write_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic done_a,
  input  logic done_b,
  output logic grant_a,
  output logic grant_b
);

  port_t last;

  // Remember which port completed most recently; reset favours A on the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       last <= PORT_B;
    else if (done_a) last <= PORT_A;
    else if (done_b) last <= PORT_B;
  end

  // Single requester wins outright; on a tie the port not served last wins.
  always_comb begin
    grant_a = req_a && (!req_b || (last == PORT_B));
    grant_b = req_b && (!req_a || (last == PORT_A));
  end

endmodule

// File: rtl/column_write_arbiter.sv
// Serialises pixel writes from two requesters onto the shared column bus,
// runs the per-column return_sig handshake and reports done/timeout/bad column.
module column_write_arbiter
  import column_write_arbiter_pkg::*;
#(
  parameter int N_COLS  = DEF_N_COLS,
  parameter int COL_W   = DEF_COL_W,
  parameter int ROW_W   = DEF_ROW_W,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                  clock,
  input logic                  reset,
  column_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  port_t            owner;
  logic [COL_W-1:0] col_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             grant_a;
  logic             grant_b;
  logic             take;
  logic             col_ok;
  logic             ack;
  logic [COL_W-1:0] col_in;
  logic [ROW_W-1:0] row_in;
  logic [PIX_W-1:0] color_in;

  rr_arbiter_2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req_a   (bus.req_a),
    .req_b   (bus.req_b),
    .done_a  (bus.done_a),
    .done_b  (bus.done_b),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  // Grant qualification, selected request fields and the observed acknowledge.
  // A grant is held off while a done pulse is out so the finishing requester
  // has a cycle to drop its request.
  always_comb begin
    cnt_inc  = cnt + 1'b1;
    take     = (state == ST_IDLE) && !bus.done_a && !bus.done_b && (grant_a || grant_b);
    col_in   = grant_b ? bus.col_b   : bus.col_a;
    row_in   = grant_b ? bus.row_b   : bus.row_a;
    color_in = grant_b ? bus.color_b : bus.color_a;
    col_ok   = int'(col_in) < N_COLS;
    ack      = bus.return_sig[col_q];
    bus.busy = (state != ST_IDLE);
  end

  // Transaction FSM: latch on grant, strobe until ack or timeout, then wait for ack low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      owner           <= PORT_A;
      col_q           <= '0;
      cnt             <= '0;
      bus.col_select  <= '0;
      bus.row_select  <= '0;
      bus.pixel_color <= '0;
      bus.done_a      <= 1'b0;
      bus.done_b      <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.bad_col_err <= 1'b0;
    end else begin
      bus.done_a <= 1'b0;
      bus.done_b <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            owner <= grant_b ? PORT_B : PORT_A;
            col_q <= col_in;
            cnt   <= '0;
            if (col_ok) begin
              bus.col_select  <= N_COLS'(1) << col_in;
              bus.row_select  <= row_in;
              bus.pixel_color <= color_in;
              state           <= ST_DRIVE;
            end else begin
              // Unaddressable column: report and complete without touching the bus.
              bus.bad_col_err <= 1'b1;
              bus.done_a      <= grant_a;
              bus.done_b      <= grant_b;
            end
          end
        end
        ST_DRIVE: begin
          if (ack || (cnt_inc == CNT_W'(TIMEOUT))) begin
            bus.col_select <= '0;
            bus.done_a     <= (owner == PORT_A);
            bus.done_b     <= (owner == PORT_B);
            cnt            <= '0;
            state          <= ST_RELEASE;
            if (!ack) bus.timeout_err <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RELEASE: begin
          if (!ack) begin
            state <= ST_IDLE;
          end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
            bus.timeout_err <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_write_arbiter.sv
// Self-checking bench for column_write_arbiter: directed scenarios plus a
// randomized section, checked against a transaction-level model of the arbiter.
module tb_column_write_arbiter;

  localparam int NC = 40;
  localparam int CW = 6;
  localparam int RW = 10;
  localparam int PW = 8;
  localparam int TO = 255;

  logic clock = 1'b0;
  logic rst;

  column_write_arbiter_if #(.N_COLS(NC), .COL_W(CW), .ROW_W(RW), .PIX_W(PW)) bus ();

  column_write_arbiter #(
    .N_COLS(NC), .COL_W(CW), .ROW_W(RW), .PIX_W(PW), .TIMEOUT(TO)
  ) dut (
    .clock (clock),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Column memory responder configuration.
  int          ack_delay = 0;
  int          hold      = 0;
  logic [NC-1:0] stuck_mask = '0;
  logic [NC-1:0] ack_reg    = '0;
  int          strobe_age = 0;
  int          rel_left   = 0;

  // Model state.
  bit last_b;
  bit exp_to;
  bit exp_bad;
  int first_done_cyc;

  logic prev_da = 1'b0;
  logic prev_db = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Next port to be served: tie goes to the port not served last.
  function automatic bit pick(input bit a, input bit b);
    if (a && b) return !last_b;
    return !a;
  endfunction

  // Cycles the strobe should stay visible for a write to column c.
  function automatic int exp_len(input int c);
    if (stuck_mask[c]) return 1;
    if (ack_delay < 0 || ack_delay >= TO) return TO;
    return ack_delay + 1;
  endfunction

  // Column memory model: ack ack_delay cycles into the strobe, drop hold cycles after it clears.
  always @(negedge clock) begin
    if (rst) begin
      ack_reg    = '0;
      strobe_age = 0;
    end else if (bus.col_select != '0) begin
      if (ack_delay >= 0 && strobe_age == ack_delay) ack_reg = ack_reg | bus.col_select;
      strobe_age++;
      rel_left = hold;
    end else begin
      strobe_age = 0;
      if (ack_reg != '0) begin
        if (rel_left == 0) ack_reg = '0;
        else rel_left--;
      end
    end
    bus.return_sig = ack_reg | stuck_mask;
  end

  // Cycle-by-cycle bus invariants.
  always @(negedge clock) begin
    if (rst) begin
      prev_da = 1'b0;
      prev_db = 1'b0;
    end else begin
      check("col_select_onehot0", 64'($onehot0(bus.col_select)), 1);
      check("dual_done", bus.done_a && bus.done_b, 0);
      check("done_width", (bus.done_a && prev_da) || (bus.done_b && prev_db), 0);
      check("grant_on_done", (prev_da || prev_db) && (bus.col_select != '0), 0);
      prev_da = bus.done_a;
      prev_db = bus.done_b;
    end
  end

  task automatic run_pair(input bit ra, input bit rb,
                          input logic [CW-1:0] ca, input logic [CW-1:0] cb,
                          input logic [RW-1:0] wa, input logic [RW-1:0] wb,
                          input logic [PW-1:0] pa, input logic [PW-1:0] pb,
                          input int dly, input bit settle);
    bit pend_a, pend_b, ep, seen;
    int slen;
    logic [CW-1:0] c;
    ack_delay   = dly;
    bus.col_a   = ca;  bus.row_a = wa;  bus.color_a = pa;
    bus.col_b   = cb;  bus.row_b = wb;  bus.color_b = pb;
    bus.req_a   = ra;  bus.req_b = rb;
    pend_a = ra;  pend_b = rb;
    ep = pick(pend_a, pend_b);
    seen = 0;  slen = 0;  first_done_cyc = -1;
    for (int cyc = 0; cyc < 4 * TO && (pend_a || pend_b); cyc++) begin
      @(posedge clock); #1;
      c = ep ? cb : ca;
      if (bus.col_select != '0) begin
        if (!seen) begin
          check("strobe_col", bus.col_select, 64'(1) << c);
          check("row_select", bus.row_select, ep ? wb : wa);
          check("pixel_color", bus.pixel_color, ep ? pb : pa);
          seen = 1;
        end
        slen++;
      end
      if (bus.done_a || bus.done_b) begin
        if (first_done_cyc < 0) first_done_cyc = cyc;
        check("done_a", bus.done_a, !ep);
        check("done_b", bus.done_b, ep);
        if (int'(c) >= NC) begin
          check("badcol_strobe_len", slen, 0);
          exp_bad = 1;
        end else begin
          check("strobe_len", slen, exp_len(int'(c)));
          if (!stuck_mask[c] && (ack_delay < 0 || ack_delay >= TO)) exp_to = 1;
        end
        last_b = ep;
        if (ep) begin pend_b = 0; bus.req_b = 1'b0; end
        else    begin pend_a = 0; bus.req_a = 1'b0; end
        ep = pick(pend_a, pend_b);
        seen = 0;  slen = 0;
      end
    end
    check("pending_served", pend_a || pend_b, 0);
    if (settle) begin
      for (int k = 0; k < TO + 20 && bus.busy; k++) begin
        @(posedge clock); #1;
      end
      check("settle_busy", bus.busy, 0);
      check("timeout_err", bus.timeout_err, exp_to);
      check("bad_col_err", bus.bad_col_err, exp_bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_a = 1'b0; bus.col_a = '0; bus.row_a = '0; bus.color_a = '0;
    bus.req_b = 1'b0; bus.col_b = '0; bus.row_b = '0; bus.color_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_col_select", bus.col_select, 0);
    check("rst_row_select", bus.row_select, 0);
    check("rst_pixel_color", bus.pixel_color, 0);
    check("rst_done_a", bus.done_a, 0);
    check("rst_done_b", bus.done_b, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_bad_col_err", bus.bad_col_err, 0);
    #2 rst = 1'b0;
    last_b = 1;  exp_to = 0;  exp_bad = 0;
    @(posedge clock); #1;

    // Single write, ack 3 cycles into the strobe; busy holds until the ack drops.
    hold = 0;
    run_pair(1, 0, 6'd5, 6'd0, 10'd17, 10'd0, 8'hFF, 8'h00, 3, 0);
    check("t1_busy_ack_high", bus.busy, 1);
    check("t1_ack_high", bus.return_sig[5], 1);
    @(posedge clock); #1;
    check("t1_busy_after_drop", bus.busy, 0);
    check("t1_row_kept", bus.row_select, 17);
    check("t1_color_kept", bus.pixel_color, 8'hFF);
    check("t1_no_errors", {bus.timeout_err, bus.bad_col_err}, 0);

    // Never acknowledged: strobe for TIMEOUT cycles, then the next request still runs.
    run_pair(1, 0, 6'd12, 6'd0, 10'd100, 10'd0, 8'h3C, 8'h00, -1, 1);
    run_pair(0, 1, 6'd0, 6'd7, 10'd0, 10'd200, 8'h00, 8'hA5, 2, 1);

    // Both ports held for three writes each with immediate acks: A,B,A,B,A,B.
    for (int i = 0; i < 3; i++)
      run_pair(1, 1, CW'(3 + i), CW'(20 + i), RW'(10 * i), RW'(500 + i),
               PW'(i), PW'(8'h80 + i), 0, 1);

    // Acknowledge stuck high on column 9 before the grant.
    stuck_mask[9] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    run_pair(1, 0, 6'd9, 6'd0, 10'd33, 10'd0, 8'h11, 8'h00, 2, 0);
    bus.req_a = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
      check("stuck_no_strobe", bus.col_select, 0);
      check("stuck_busy", bus.busy, 1);
    end
    stuck_mask[9] = 1'b0;
    run_pair(1, 0, 6'd9, 6'd0, 10'd34, 10'd0, 8'h22, 8'h00, 1, 1);

    // Column outside the populated range.
    run_pair(0, 1, 6'd0, 6'd50, 10'd0, 10'd7, 8'h00, 8'h77, 1, 1);
    check("badcol_latency", first_done_cyc <= 1, 1);

    // Randomized traffic, occasional bad columns, varying ack and release timing.
    for (int it = 0; it < 24; it++) begin
      bit ra, rb;
      logic [CW-1:0] ca, cb;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1;
      ca = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(NC, 63)) : CW'($urandom_range(0, NC - 1));
      cb = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(NC, 63)) : CW'($urandom_range(0, NC - 1));
      hold = $urandom_range(0, 2);
      run_pair(ra, rb, ca, cb, RW'($urandom), RW'($urandom), PW'($urandom), PW'($urandom),
               $urandom_range(0, 4), 1);
    end

    // Reset in the middle of a DRIVE phase.
    hold = 0;
    ack_delay = -1;
    bus.col_a = 6'd7;  bus.row_a = 10'd9;  bus.color_a = 8'h5A;
    bus.req_a = 1'b1;
    repeat (5) begin @(posedge clock); #1; end
    check("pre_reset_strobe", bus.col_select, 64'(1) << 7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_col_select", bus.col_select, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_timeout_err", bus.timeout_err, 0);
    check("async_rst_bad_col_err", bus.bad_col_err, 0);
    check("async_rst_done", {bus.done_a, bus.done_b}, 0);
    bus.req_a = 1'b0;
    @(posedge clock);
    #3 rst = 1'b0;
    last_b = 1;  exp_to = 0;  exp_bad = 0;
    @(posedge clock); #1;
    run_pair(1, 1, 6'd2, 6'd4, 10'd1, 10'd2, 8'h01, 8'h02, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
